// File: rtl/rv32_pkg.sv
// Shared RV32 constants and fetch FSM state type for the front end.
// The static BTFN predictor is enabled with the FETCH_STATIC_BTFN_EN macro.
package rv32_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2,
    FS_DROP = 2'd3
  } fetch_state_e;

  function automatic logic signed [31:0] b_imm(input logic [31:0] instr);
    logic signed [12:0] imm;
    imm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    return 32'(imm);
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next fetch address and prediction flag for the word just fetched.
// FETCH_STATIC_BTFN_EN selects backward-taken/forward-not-taken branch prediction.
module fetch_next_pc
  import rv32_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] next_pc,
  output logic        pred_taken
);

`ifdef FETCH_STATIC_BTFN_EN
  logic back_branch;

  // A negative B-immediate has its sign in instr[31]: predict backward branches taken.
  assign back_branch = (instr[6:0] == OPC_BRANCH) && instr[31];
  assign pred_taken  = back_branch;
  assign next_pc     = back_branch ? (pc + $unsigned(b_imm(instr))) : (pc + 32'd4);
`else
  logic unused_instr;

  assign unused_instr = ^instr;
  assign pred_taken   = 1'b0;
  assign next_pc      = pc + 32'd4;
`endif

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with a single outstanding memory request, skid buffer and IF/ID register.
// Optional static branch prediction via the FETCH_STATIC_BTFN_EN macro (see fetch_next_pc).
module fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic        pred_taken
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  skid_q;
  logic         skid_load;
  logic         load_new;
  logic [31:0]  fetch_word;
  logic [31:0]  next_pc;
  logic         next_pred;

  logic [31:0]  instr_p1;
  logic [31:0]  pc_p1;
  logic [31:0]  pc_plus4_p1;
  logic         vld_p1;
  logic         pred_p1;

  // pc_q stays on the fetched address until the word leaves WAIT/HOLD, so it pairs with either source.
  assign fetch_word = (state_q == FS_HOLD) ? skid_q : imem_rdata;
  assign imem_addr  = {pc_q[31:2], 2'b00};

  fetch_next_pc u_next_pc (
    .pc         (pc_q),
    .instr      (fetch_word),
    .next_pc    (next_pc),
    .pred_taken (next_pred)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    imem_req  = 1'b0;
    load_new  = 1'b0;
    skid_load = 1'b0;
    case (state_q)
      FS_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_d = redirect_pc;
          if (imem_gnt) state_d = FS_DROP;
        end else if (imem_gnt) begin
          state_d = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = imem_rvalid ? FS_REQ : FS_DROP;
        end else if (imem_rvalid) begin
          if (stall) begin
            skid_load = 1'b1;
            state_d   = FS_HOLD;
          end else begin
            load_new = 1'b1;
            pc_d     = next_pc;
            state_d  = FS_REQ;
          end
        end
      end
      FS_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = FS_REQ;
        end else if (!stall) begin
          load_new = 1'b1;
          pc_d     = next_pc;
          state_d  = FS_REQ;
        end
      end
      FS_DROP: begin
        if (redirect) pc_d = redirect_pc;
        if (imem_rvalid) state_d = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FS_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (skid_load) skid_q <= imem_rdata;
  end

  // ---- IF/ID boundary: flush > stall > load, otherwise a bubble ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_p1    <= NOP_INSTR;
      pc_p1       <= 32'h0;
      pc_plus4_p1 <= 32'h0;
      vld_p1      <= 1'b0;
      pred_p1     <= 1'b0;
    end else if (flush) begin
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
      pred_p1  <= 1'b0;
    end else if (!stall) begin
      if (load_new) begin
        instr_p1    <= fetch_word;
        pc_p1       <= pc_q;
        pc_plus4_p1 <= pc_q + 32'd4;
        vld_p1      <= 1'b1;
        pred_p1     <= next_pred;
      end else begin
        instr_p1 <= NOP_INSTR;
        vld_p1   <= 1'b0;
        pred_p1  <= 1'b0;
      end
    end
  end

  assign instruction = instr_p1;
  assign pc          = pc_p1;
  assign pc_plus4    = pc_plus4_p1;
  assign if_valid    = vld_p1;
  assign pred_taken  = pred_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory responder, fetch-stream reference model, directed scenarios.
// Honours FETCH_STATIC_BTFN_EN the same way the design does.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction, pc, pc_plus4;
  logic        if_valid, pred_taken;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .if_valid    (if_valid),
    .pred_taken  (pred_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Instruction memory image: ADDI words tagged with their address, one backward branch at 0x20.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h20) return 32'hFE00_08E3;  // beq x0,x0,-16
    return {a[13:2], 5'd1, 3'b000, 5'd1, 7'h13};
  endfunction

  // Architectural successor of a fetched word: {prediction, next address}.
  function automatic logic [32:0] model_step(input logic [31:0] a, input logic [31:0] w);
    logic [12:0] off;
    off = {w[31], w[7], w[30:25], w[11:8], 1'b0};
`ifdef FETCH_STATIC_BTFN_EN
    if (w[6:0] == 7'b1100011 && w[31]) return {1'b1, a + {{19{off[12]}}, off}};
`endif
    return {off[0], a + 32'd4};
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  logic        l_stall, l_flush, l_redirect, l_rst;
  logic [31:0] l_rpc;
  logic [31:0] exp_pc;
  logic [97:0] prev_ifid;
  logic [32:0] step;
  int          deliveries = 0;

  always @(posedge clk) begin
    l_stall    = stall;
    l_flush    = flush;
    l_redirect = redirect;
    l_rpc      = redirect_pc;
    l_rst      = rst;
  end

  always @(negedge clk) begin
    if (!rst || !l_rst) begin
      exp_pc = RESET_PC;
    end else begin
      if (l_flush) begin
        chk("flush_bubble", {instruction, if_valid, pred_taken}, {NOP, 1'b0, 1'b0});
      end else if (l_stall) begin
        chk("stall_hold", {instruction, pc, pc_plus4, if_valid, pred_taken}, prev_ifid);
      end else if (if_valid) begin
        if (l_redirect) begin
          chk("load_on_redirect", if_valid, 1'b0);
        end else begin
          step = model_step(exp_pc, mem_word(exp_pc));
          chk("delivery", {pc, instruction, pc_plus4, pred_taken},
              {exp_pc, mem_word(exp_pc), exp_pc + 32'd4, step[32]});
          exp_pc = step[31:0];
          deliveries++;
        end
      end else begin
        chk("bubble", {instruction, pred_taken}, {NOP, 1'b0});
      end
      if (l_redirect) exp_pc = l_rpc;
      if (imem_req) chk("req_addr", imem_addr, exp_pc);
    end
    prev_ifid = {instruction, pc, pc_plus4, if_valid, pred_taken};
  end

  // ---------------- memory responder and driver ----------------
  logic        gnt_en = 1'b1;
  int          lat = 1;
  int          resp_cnt = 0;
  logic [31:0] resp_word = 32'h0;

  task automatic tick();
    logic        g;
    logic [31:0] ga;
    imem_gnt    = gnt_en;
    imem_rvalid = (resp_cnt == 1);
    imem_rdata  = imem_rvalid ? resp_word : 32'hDEAD_BEEF;
    g  = rst && imem_req && imem_gnt;
    ga = imem_addr;
    @(posedge clk);
    #1;
    if (resp_cnt != 0) resp_cnt--;
    if (g) begin
      resp_cnt  = lat;
      resp_word = mem_word(ga);
    end
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20 && !imem_req; i++) tick();
    if (!imem_req) fail_now(name);
  endtask

  task automatic wait_deliv(input string name, input logic [31:0] a);
    int n;
    n = 0;
    while (!(if_valid && pc == a) && n < 40) begin
      tick();
      n++;
    end
    if (!(if_valid && pc == a)) fail_now(name);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ifid", {instruction, pc, pc_plus4, if_valid, pred_taken},
        {NOP, 32'h0, 32'h0, 1'b0, 1'b0});
    rst = 1'b1;
    chk("first_req", {imem_req, imem_addr}, {1'b1, RESET_PC});

    // Back-to-back fetch with gnt/rvalid always ready.
    tick(); tick();
    chk("lat_first", {if_valid, pc, pc_plus4, instruction}, {1'b1, 32'h0, 32'h4, 32'h0000_8093});
    tick();
    chk("lat_bubble", if_valid, 1'b0);
    tick();
    chk("seq_pc4", {if_valid, pc, instruction}, {1'b1, 32'h4, 32'h0010_8093});
    repeat (6) tick();
    chk("seq_pc16", {if_valid, pc, imem_req, imem_addr}, {1'b1, 32'h10, 1'b1, 32'h14});

    // Stall across the response: skid into HOLD, release once.
    stall = 1'b1;
    repeat (3) tick();
    chk("stall_held", {if_valid, pc, imem_req}, {1'b1, 32'h10, 1'b0});
    stall = 1'b0;
    tick();
    chk("stall_release", {if_valid, pc, instruction, imem_addr}, {1'b1, 32'h14, 32'h0050_8093, 32'h18});

    // Redirect while waiting on a slow response.
    lat = 3;
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    lat = 1;
    wait_req("wait_after_redirect");
    chk("redirect_addr", {imem_addr, if_valid}, {32'h100, 1'b0});
    wait_deliv("deliv_100", 32'h100);

    // Flush and stall together.
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    chk("flush_stall", {instruction, if_valid, pred_taken}, {NOP, 1'b0, 1'b0});
    wait_deliv("deliv_104", 32'h104);

    // Redirect in REQ without grant, then branch at 0x20.
    wait_req("wait_br");
    gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    tick();
    gnt_en = 1'b1;
    wait_deliv("deliv_branch", 32'h20);
`ifdef FETCH_STATIC_BTFN_EN
    chk("btfn_taken", {pred_taken, imem_req, imem_addr}, {1'b1, 1'b1, 32'h10});
`else
    chk("btfn_off", {pred_taken, imem_req, imem_addr}, {1'b0, 1'b1, 32'h24});
`endif

    // Redirect in REQ with grant (DROP), then wrap at the top of memory.
    wait_req("wait_wrap");
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    wait_deliv("deliv_wrap", 32'hFFFF_FFFC);
    chk("wrap", {instruction, pc_plus4, imem_req, imem_addr}, {32'hFFF0_8093, 32'h0, 1'b1, 32'h0});

    // Redirect while the response sits in the skid buffer.
    wait_req("wait_hold");
    stall = 1'b1;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0; stall = 1'b0;
    wait_deliv("deliv_40", 32'h40);
    chk("hold_redirect", {instruction, pc_plus4}, {32'h0100_8093, 32'h44});

    repeat (6) tick();
    @(negedge clk);
    #1;
    if (deliveries < 12) chk("delivery_count", deliveries, 12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
